// File: rtl/fifo_reader_pkg.sv
// Shared constants for the sample-FIFO burst reader: state encoding and default widths.
package fifo_reader_pkg;

  localparam int WIDTH_DEF  = 3;
  localparam int HOLD_W_DEF = 8;
  localparam int CNT_W_DEF  = 8;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

endpackage

// File: rtl/fifo_burst_reader_symbol_hold_timer.sv
// Loadable down-counter that times how long a symbol stays on the pulser output.
module symbol_hold_timer
  import fifo_reader_pkg::*;
#(
  parameter int HOLD_W = HOLD_W_DEF
)(
  input  logic              Clock,
  input  logic              reset,
  input  logic              load,
  input  logic [HOLD_W-1:0] load_value,
  input  logic              count_en,
  output logic              expired,
  output logic              two_left
);

  logic [HOLD_W-1:0] value;

  // Load wins over counting so a back-to-back symbol restarts cleanly on its expiry cycle.
  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) begin
      value <= '0;
    end else if (load) begin
      value <= load_value;
    end else if (count_en && (value != '0)) begin
      value <= value - 1'b1;
    end
  end

  assign expired  = (value == HOLD_W'(1));
  assign two_left = (value == HOLD_W'(2));

endmodule

// File: rtl/fifo_burst_reader.sv
// Read-side burst controller for the sample FIFO; drives the pulser with held symbols.
// Define PREFETCH_EN for gap-free output (next symbol fetched during the current hold).
module fifo_burst_reader
  import fifo_reader_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int HOLD_W = HOLD_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
)(
  input  logic              Clock,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  burst_len,
  input  logic [HOLD_W-1:0] hold_cycles,
  input  logic              fifo_empty,
  input  logic [WIDTH-1:0]  fifo_read_data,
  output logic              fifo_read_en,
  output logic [WIDTH-1:0]  pulse_code,
  output logic              pulse_valid,
  output logic              busy,
  output logic              done,
  output logic              underrun
);

  logic [2:0]        state;
  logic [CNT_W-1:0]  remaining;
  logic [HOLD_W-1:0] hold_len;
  logic [HOLD_W-1:0] hold_eff;
  logic              issued;
  logic              timer_load;
  logic              timer_expired;
  logic              timer_two_left;
  logic              fetch_read;

  assign fetch_read = (state == ST_FETCH) && !fifo_empty;
  assign busy       = (state != ST_IDLE);
  assign done       = (state == ST_DONE);

`ifdef PREFETCH_EN
  logic prefetch_read;
  logic prefetch_load;
  logic prefetched;

  // The prefetch needs one cycle of FIFO latency inside the hold, so the hold is at least 2.
  assign hold_eff      = (hold_cycles < HOLD_W'(2)) ? HOLD_W'(2) : hold_cycles;
  assign prefetch_read = (state == ST_HOLD) && timer_two_left && (remaining != '0) && !fifo_empty;
  assign prefetch_load = (state == ST_HOLD) && timer_expired && prefetched;
  assign fifo_read_en  = fetch_read || prefetch_read;
  assign timer_load    = (state == ST_WAIT) || prefetch_load;

  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) begin
      prefetched <= 1'b0;
    end else begin
      prefetched <= prefetch_read;
    end
  end
`else
  logic unused_two_left;

  assign hold_eff        = (hold_cycles == '0) ? HOLD_W'(1) : hold_cycles;
  assign fifo_read_en    = fetch_read;
  assign timer_load      = (state == ST_WAIT);
  assign unused_two_left = timer_two_left;
`endif

  symbol_hold_timer #(
    .HOLD_W (HOLD_W)
  ) u_hold_timer (
    .Clock      (Clock),
    .reset      (reset),
    .load       (timer_load),
    .load_value (hold_len),
    .count_en   (state == ST_HOLD),
    .expired    (timer_expired),
    .two_left   (timer_two_left)
  );

  // Burst sequencing; underrun only counts once the burst has actually put a symbol out.
  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      remaining   <= '0;
      hold_len    <= '0;
      issued      <= 1'b0;
      underrun    <= 1'b0;
      pulse_code  <= '0;
      pulse_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (burst_len == '0) begin
              state <= ST_DONE;
            end else begin
              remaining <= burst_len;
              hold_len  <= hold_eff;
              issued    <= 1'b0;
              underrun  <= 1'b0;
              state     <= ST_FETCH;
            end
          end
        end
        ST_FETCH: begin
          if (!fifo_empty) begin
            state <= ST_WAIT;
          end else if (issued) begin
            underrun <= 1'b1;
          end
        end
        ST_WAIT: begin
          pulse_code  <= fifo_read_data;
          pulse_valid <= 1'b1;
          remaining   <= remaining - 1'b1;
          issued      <= 1'b1;
          state       <= ST_HOLD;
        end
        ST_HOLD: begin
          if (timer_expired) begin
`ifdef PREFETCH_EN
            if (prefetched) begin
              pulse_code <= fifo_read_data;
              remaining  <= remaining - 1'b1;
            end else
`endif
            begin
              pulse_code  <= '0;
              pulse_valid <= 1'b0;
              state       <= (remaining != '0) ? ST_FETCH : ST_DONE;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Scoreboard bench for fifo_burst_reader with a registered-read FIFO model.
// Expectations follow PREFETCH_EN when the bench is built with it.
module tb_fifo_burst_reader;

  localparam int WIDTH  = 3;
  localparam int HOLD_W = 8;
  localparam int CNT_W  = 8;

  typedef struct {
    int code;
    int first;
    int len;
  } sym_t;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [CNT_W-1:0]  burst_len = '0;
  logic [HOLD_W-1:0] hold_cycles = '0;
  logic              fifo_empty;
  logic [WIDTH-1:0]  fifo_read_data = '0;
  logic              fifo_read_en;
  logic [WIDTH-1:0]  pulse_code;
  logic              pulse_valid;
  logic              busy;
  logic              done;
  logic              underrun;

  logic [WIDTH-1:0] fifo_mem [16];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  sym_t exp_sym[$];
  int   exp_rd[$];
  int   exp_done[$];

  int run_code  = 0;
  int run_first = 0;
  int run_len   = 0;
  bit in_run    = 1'b0;

  fifo_burst_reader #(
    .WIDTH  (WIDTH),
    .HOLD_W (HOLD_W),
    .CNT_W  (CNT_W)
  ) dut (
    .Clock          (clock),
    .reset          (reset),
    .start          (start),
    .burst_len      (burst_len),
    .hold_cycles    (hold_cycles),
    .fifo_empty     (fifo_empty),
    .fifo_read_data (fifo_read_data),
    .fifo_read_en   (fifo_read_en),
    .pulse_code     (pulse_code),
    .pulse_valid    (pulse_valid),
    .busy           (busy),
    .done           (done),
    .underrun       (underrun)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // FIFO model: one-cycle registered read latency
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clock) begin
    if (fifo_read_en && !fifo_empty) begin
      fifo_read_data <= fifo_mem[rd_ptr % 16];
      rd_ptr         <= rd_ptr + 1;
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic report_unexpected(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got an event at cycle %0d expected none", name, cyc);
  endtask

  task automatic close_run();
    sym_t e;
    if (exp_sym.size() == 0) begin
      report_unexpected("symbol");
    end else begin
      e = exp_sym.pop_front();
      checkOutput("symbol_code", run_code, e.code);
      checkOutput("symbol_first_cycle", run_first, e.first);
      checkOutput("symbol_hold_len", run_len, e.len);
    end
    in_run = 1'b0;
  endtask

  task automatic push_sym(input int code, input int first, input int len);
    sym_t e;
    e.code  = code;
    e.first = first;
    e.len   = len;
    exp_sym.push_back(e);
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #2;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) next_cycle();
  endtask

  task automatic fifo_write(input int v);
    fifo_mem[wr_ptr % 16] = WIDTH'(v);
    wr_ptr++;
  endtask

  task automatic applyStimulus(input int len, input int hold, output int t0);
    start       = 1'b1;
    burst_len   = CNT_W'(len);
    hold_cycles = HOLD_W'(hold);
    t0          = cyc;
    next_cycle();
    start       = 1'b0;
  endtask

  // Monitor: sampled on the falling edge, pops the scoreboard whenever the DUT shows an event
  always @(negedge clock) begin
    if (pulse_valid && (!in_run || int'(pulse_code) != run_code)) begin
      if (in_run) close_run();
      in_run    = 1'b1;
      run_code  = int'(pulse_code);
      run_first = cyc;
      run_len   = 1;
    end else if (pulse_valid) begin
      run_len++;
    end else if (in_run) begin
      close_run();
    end
    if (!pulse_valid) checkOutput("code_zero_when_idle", int'(pulse_code), 0);
    if (fifo_read_en) begin
      checkOutput("read_only_when_nonempty", int'(fifo_empty), 0);
      if (exp_rd.size() == 0) report_unexpected("fifo_read_en");
      else checkOutput("read_cycle", cyc, exp_rd.pop_front());
    end
    if (done) begin
      if (exp_done.size() == 0) report_unexpected("done");
      else checkOutput("done_cycle", cyc, exp_done.pop_front());
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no finish by %0t expected finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t0;
    int rd_before;

    // Reset state, with data waiting so a stray read would be visible
    fifo_write(3);
    fifo_write(5);
    fifo_write(7);
    next_cycle();
    next_cycle();
    checkOutput("reset_pulse_code", int'(pulse_code), 0);
    checkOutput("reset_pulse_valid", int'(pulse_valid), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done", int'(done), 0);
    checkOutput("reset_underrun", int'(underrun), 0);
    checkOutput("reset_read_en", int'(fifo_read_en), 0);
    reset = 1'b1;
    next_cycle();
    next_cycle();

    // Three-symbol burst, hold 4; a start while busy must be ignored
    applyStimulus(3, 4, t0);
`ifdef PREFETCH_EN
    exp_rd.push_back(t0 + 1);
    exp_rd.push_back(t0 + 5);
    exp_rd.push_back(t0 + 9);
    push_sym(3, t0 + 3, 4);
    push_sym(5, t0 + 7, 4);
    push_sym(7, t0 + 11, 4);
    exp_done.push_back(t0 + 15);
`else
    exp_rd.push_back(t0 + 1);
    exp_rd.push_back(t0 + 7);
    exp_rd.push_back(t0 + 13);
    push_sym(3, t0 + 3, 4);
    push_sym(5, t0 + 9, 4);
    push_sym(7, t0 + 15, 4);
    exp_done.push_back(t0 + 19);
`endif
    wait_until(t0 + 5);
    start     = 1'b1;
    burst_len = '0;
    next_cycle();
    start     = 1'b0;
    wait_until(t0 + 21);
    checkOutput("burst1_underrun", int'(underrun), 0);
    checkOutput("burst1_idle", int'(busy), 0);

    // Zero-length burst; a start in the DONE cycle must be ignored
    applyStimulus(0, 4, t0);
    exp_done.push_back(t0 + 1);
    checkOutput("zero_len_busy_cycle1", int'(busy), 1);
    start       = 1'b1;
    burst_len   = CNT_W'(1);
    hold_cycles = HOLD_W'(1);
    next_cycle();
    start       = 1'b0;
    checkOutput("zero_len_busy_cycle2", int'(busy), 0);
    next_cycle();
    checkOutput("start_in_done_ignored", int'(busy), 0);

    // Underrun: one entry for a two-symbol burst, second entry arrives late
    fifo_write(4);
    applyStimulus(2, 3, t0);
    exp_rd.push_back(t0 + 1);
    push_sym(4, t0 + 3, 3);
    wait_until(t0 + 8);
    checkOutput("underrun_set", int'(underrun), 1);
    checkOutput("underrun_still_busy", int'(busy), 1);
    wait_until(t0 + 9);
    fifo_write(6);
    exp_rd.push_back(t0 + 9);
    push_sym(6, t0 + 11, 3);
    exp_done.push_back(t0 + 14);
    wait_until(t0 + 16);
    checkOutput("underrun_sticky", int'(underrun), 1);

    // Hold of zero treated as the minimum hold; the new start clears underrun
    fifo_write(1);
    fifo_write(2);
    applyStimulus(2, 0, t0);
    checkOutput("underrun_cleared", int'(underrun), 0);
`ifdef PREFETCH_EN
    exp_rd.push_back(t0 + 1);
    exp_rd.push_back(t0 + 3);
    push_sym(1, t0 + 3, 2);
    push_sym(2, t0 + 5, 2);
`else
    exp_rd.push_back(t0 + 1);
    exp_rd.push_back(t0 + 4);
    push_sym(1, t0 + 3, 1);
    push_sym(2, t0 + 6, 1);
`endif
    exp_done.push_back(t0 + 7);
    wait_until(t0 + 10);

    // Reset in the middle of a hold, then a fresh burst from the untouched FIFO contents
    fifo_write(2);
    fifo_write(4);
    fifo_write(6);
    applyStimulus(3, 5, t0);
    exp_rd.push_back(t0 + 1);
    push_sym(2, t0 + 3, 3);
    wait_until(t0 + 5);
    @(negedge clock);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("midreset_pulse_code", int'(pulse_code), 0);
    checkOutput("midreset_pulse_valid", int'(pulse_valid), 0);
    checkOutput("midreset_busy", int'(busy), 0);
    checkOutput("midreset_done", int'(done), 0);
    checkOutput("midreset_read_en", int'(fifo_read_en), 0);
    rd_before = rd_ptr;
    @(posedge clock);
    @(posedge clock);
    #2;
    checkOutput("midreset_fifo_untouched", rd_ptr, rd_before);
    @(negedge clock);
    #1;
    reset = 1'b1;
    next_cycle();
    next_cycle();
    applyStimulus(2, 2, t0);
`ifdef PREFETCH_EN
    exp_rd.push_back(t0 + 1);
    exp_rd.push_back(t0 + 3);
    push_sym(4, t0 + 3, 2);
    push_sym(6, t0 + 5, 2);
    exp_done.push_back(t0 + 7);
`else
    exp_rd.push_back(t0 + 1);
    exp_rd.push_back(t0 + 5);
    push_sym(4, t0 + 3, 2);
    push_sym(6, t0 + 7, 2);
    exp_done.push_back(t0 + 9);
`endif
    wait_until(t0 + 12);

    checkOutput("fifo_drained", rd_ptr, wr_ptr);
    checkOutput("symbols_outstanding", exp_sym.size(), 0);
    checkOutput("reads_outstanding", exp_rd.size(), 0);
    checkOutput("dones_outstanding", exp_done.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
